fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Instruction fetch sequencer for the RISC-V core. Owns the fetch PC and issues word reads to the
//  instruction memory over a req/ready + rvalid port, tolerating latency >= 1 cycle. Buffers
//  returned words with their PC in a prefetch FIFO and hands them to decode over valid/ready.
//  On a branch/jump redirect it flushes the FIFO and discards responses still in flight.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded at reset (word aligned)
//  FIFO_DEPTH  4              prefetch entries; also the max credit (outstanding + buffered); power of 2, >= 2
// PORTS
//  clk             in   1   core clock, all state on rising edge
//  reset_n         in   1   asynchronous active-low reset
//  mem_req         out  1   read request to instruction memory
//  mem_addr        out  32  byte address of request, [1:0] always 0
//  mem_ready       in   1   memory accepts request this cycle (mem_req && mem_ready = issue)
//  mem_rvalid      in   1   read data valid; responses return in issue order, one per issue
//  mem_rdata       in   32  instruction word
//  redirect_valid  in   1   one-cycle pulse: flush and restart fetch
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  out_valid       out  1   instruction available to decode
//  out_ready       in   1   decode consumes (out_valid && out_ready = pop)
//  out_instr       out  32  instruction word at FIFO head
//  out_pc          out  32  byte PC of out_instr
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0; fetch_pc=resp_pc=RESET_PC;
//   outstanding=0, drop_cnt=0, FIFO empty. Reset mid-transaction abandons all in-flight reads.
//  Issue: mem_req = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH); mem_addr = fetch_pc.
//   On issue: fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC -> 0), outstanding += 1.
//   Request may be withdrawn only by redirect; otherwise mem_addr is held stable while mem_req && !mem_ready.
//  Response: each mem_rvalid decrements outstanding. If drop_cnt != 0: discard, drop_cnt -= 1.
//   Else push {resp_pc, mem_rdata}; resp_pc += 4 (same wrap). Issue and response in same cycle: net outstanding unchanged.
//  Credit rule guarantees no push into a full FIFO; mem_rvalid with outstanding == 0 is illegal (assertion).
//  Output: out_valid = FIFO not empty; out_instr/out_pc = head, registered (FIFO storage), zero-latency
//   from head. Pop on out_valid && out_ready. Push and pop in the same cycle on a full FIFO are legal.
//  Latency: redirect at cycle N -> mem_req with new PC at N+1 -> earliest out_valid at N+1+L+1 (L = memory latency).
//  Redirect (highest priority, cycle N): FIFO cleared (out_valid=0 from N+1), any pop in N ignored;
//   fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}; any mem_rvalid in N discarded;
//   drop_cnt = outstanding - mem_rvalid (all in-flight reads become stale); no issue in N.
//  Back-to-back redirects: each restarts; drop_cnt recomputed from current outstanding.
//  Counters: outstanding and drop_cnt are $clog2(FIFO_DEPTH+1) bits, never exceed FIFO_DEPTH.
//  Stall: out_ready low holds the head; fetch stops once credits are exhausted, resumes one cycle after a pop.
// STRUCTURE
//  Package fetch_pkg: XLEN=32, INSTR_W=32, PC_STEP=4, default RESET_PC; typedef fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH param, push/pop/flush, count, empty/full.
//  Top: fetch_pc/resp_pc registers, credit counter, drop counter, issue logic, FIFO instance.
// TESTING
//  Reset, memory L=1 always ready, out_ready=1 -> out_pc sequence 0,4,8,..., one instr/cycle steady state, first out_valid at cycle 2.
//  out_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 issues then mem_req=0; release -> PCs 0,4,8,12,16 in order, no loss.
//  L=3, 3 reads outstanding, redirect_pc=32'h0000_0102 -> next mem_addr 32'h100, 3 stale rvalids dropped, first out_pc=32'h100.
//  Redirect in same cycle as mem_rvalid and pop -> that response dropped, drop_cnt=outstanding-1, out_valid=0 next cycle.
//  redirect_pc=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
//  Random mem_ready/rvalid latency 1..4 plus random redirects, reference PC model -> every out_pc/out_instr matches, no overflow assertion.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, PC step and the prefetch entry type for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with registered storage and a
// combinational head; flush empties it and overrides push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = storage[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: credit-limited word reads, in-order response
// capture into the prefetch FIFO, and redirect flush with stale-response drop.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_req,
  output logic [XLEN-1:0]    mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned CRED_W = CNT_W + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   redirect_base;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};

  // Credits cover both in-flight reads and buffered words, so every response
  // is guaranteed a FIFO slot.
  assign mem_req   = reset_n && !redirect_valid && (credit_used < CRED_W'(FIFO_DEPTH));
  assign mem_addr  = fetch_pc;
  assign issue     = mem_req && mem_ready;
  assign push      = mem_rvalid && !redirect_valid && (drop_cnt == '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push_data = '{pc: resp_pc, instr: mem_rdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= outstanding - CNT_W'(mem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(mem_rvalid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_STEP;
      if (push)  resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(mem_rvalid);
      if (mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    mem_rvalid |-> (outstanding != '0));

  no_push_into_full: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (!fifo_full || pop));

endmodule
